// File: rtl/dma_job_scheduler_if.sv
// Job-request, completion and engine-config signals of dma_job_scheduler.
// The slave modport is the scheduler's view; the master modport is the system side.
interface dma_job_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_sa;
  logic [NREQ*32-1:0] req_len;

  logic               done_valid;
  logic               done_ready;
  logic [IDW-1:0]     done_id;
  logic [3:0]         done_err;

  logic               dma_valid;
  logic               dma_ready;
  logic [31:0]        dma_sa;
  logic [31:0]        dma_len;
  logic               dma_irq;
  logic               dma_irq_w1c;
  logic [3:0]         dma_err;

  modport slave (
    input  req_valid, req_sa, req_len, done_ready, dma_ready, dma_irq, dma_err,
    output req_ready, done_valid, done_id, done_err, dma_valid, dma_sa, dma_len, dma_irq_w1c
  );

  modport master (
    output req_valid, req_sa, req_len, done_ready, dma_ready, dma_irq, dma_err,
    input  req_ready, done_valid, done_id, done_err, dma_valid, dma_sa, dma_len, dma_irq_w1c
  );
endinterface

// File: rtl/dma_job_scheduler.sv
// Round-robin DMA job scheduler: splits jobs into MAX_CHUNK-aligned engine chunks, one in flight.
// Define DMA_ERR_ABORT_EN to drop a job's remaining chunks once any chunk reports an error.
module dma_job_scheduler #(
  parameter int NREQ      = 4,
  parameter int AXI_BYTES = 16,
  parameter int MAX_CHUNK = 4096,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  dma_job_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, REPORT} state_t;

`ifdef DMA_ERR_ABORT_EN
  localparam bit ABORT_ON_ERR = 1'b1;
`else
  localparam bit ABORT_ON_ERR = 1'b0;
`endif

  localparam logic [31:0] ALIGN_MASK    = ~(32'(AXI_BYTES) - 32'd1);
  localparam logic [31:0] CHUNK_MAX     = 32'(MAX_CHUNK);
  localparam logic [31:0] CHUNK_OFS_MSK = CHUNK_MAX - 32'd1;

  // Largest chunk that neither overruns the job nor crosses a MAX_CHUNK boundary.
  function automatic logic [31:0] chunk_len(input logic [31:0] a, input logic [31:0] r);
    logic [31:0] room;
    room = CHUNK_MAX - (a & CHUNK_OFS_MSK);
    return (r < room) ? r : room;
  endfunction

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] job_id;
  logic [31:0]    addr;
  logic [31:0]    rem;
  logic [3:0]     err_acc;

  logic           dma_valid_q;
  logic [31:0]    dma_sa_q;
  logic [31:0]    dma_len_q;
  logic           dma_irq_w1c_q;
  logic           done_valid_q;
  logic [IDW-1:0] done_id_q;
  logic [3:0]     done_err_q;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic [NREQ-1:0] req_ready_c;
  logic [31:0]    sel_sa;
  logic [31:0]    sel_len;

  // Circular search starting just after the last requester served.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_sa  = '0;
    sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_sa  = bus.req_sa[i*32 +: 32] & ALIGN_MASK;
        sel_len = bus.req_len[i*32 +: 32] & ALIGN_MASK;
      end
    end
  end

  // The accept pulse must coincide with the req_valid it answers, so it stays combinational.
  always_comb begin
    req_ready_c = '0;
    if (state == IDLE && grant_found && !reset) req_ready_c[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= IDW'(NREQ-1);
      job_id        <= '0;
      addr          <= '0;
      rem           <= '0;
      err_acc       <= '0;
      dma_valid_q   <= 1'b0;
      dma_sa_q      <= '0;
      dma_len_q     <= '0;
      dma_irq_w1c_q <= 1'b0;
      done_valid_q  <= 1'b0;
      done_id_q     <= '0;
      done_err_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            job_id  <= grant_idx;
            addr    <= sel_sa;
            rem     <= sel_len;
            err_acc <= '0;
            if (sel_len == '0) begin
              state        <= REPORT;
              done_valid_q <= 1'b1;
              done_id_q    <= grant_idx;
              done_err_q   <= '0;
            end else begin
              state       <= ISSUE;
              dma_valid_q <= 1'b1;
              dma_sa_q    <= sel_sa;
              dma_len_q   <= chunk_len(sel_sa, sel_len);
            end
          end
        end

        ISSUE: begin
          if (dma_valid_q && bus.dma_ready) begin
            dma_valid_q <= 1'b0;
            addr        <= addr + dma_len_q;
            rem         <= rem - dma_len_q;
            state       <= WAIT;
          end
        end

        WAIT: begin
          if (bus.dma_irq) begin
            err_acc       <= err_acc | bus.dma_err;
            dma_irq_w1c_q <= 1'b1;
            state         <= CLEAR;
          end
        end

        CLEAR: begin
          dma_irq_w1c_q <= 1'b0;
          if (rem == '0 || (ABORT_ON_ERR && err_acc != '0)) begin
            state        <= REPORT;
            done_valid_q <= 1'b1;
            done_id_q    <= job_id;
            done_err_q   <= err_acc;
          end else begin
            state       <= ISSUE;
            dma_valid_q <= 1'b1;
            dma_sa_q    <= addr;
            dma_len_q   <= chunk_len(addr, rem);
          end
        end

        REPORT: begin
          if (done_valid_q && bus.done_ready) begin
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_err_q   <= '0;
            last_grant   <= job_id;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.dma_valid   = dma_valid_q;
  assign bus.dma_sa      = dma_sa_q;
  assign bus.dma_len     = dma_len_q;
  assign bus.dma_irq_w1c = dma_irq_w1c_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_id     = done_id_q;
  assign bus.done_err    = done_err_q;

endmodule
